// File: rtl/audio_rec_ctrl.sv
// Record/playback sequencer in front of the SRAM interface: one word per
// codec sample tick, tracks recording length, flags ticks that land mid-access.
module audio_rec_ctrl #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rec_req_i,
  input  logic              play_req_i,
  input  logic              stop_req_i,
  input  logic              sample_tick_i,
  input  logic [DATA_W-1:0] sample_in_i,
  input  logic [DATA_W-1:0] data_in_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              read_o,
  output logic              write_o,
  output logic              play_o,
  output logic              record_o,
  output logic [DATA_W-1:0] sample_out_o,
  output logic              sample_out_valid_o,
  output logic [ADDR_W:0]   rec_len_o,
  output logic              done_o,
  output logic              overrun_o
);
  localparam int CNT_MAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {IDLE, REC_WAIT, REC_WR, PLAY_WAIT, PLAY_RD} state_t;
  state_t st_q, st_d;

  logic [ADDR_W-1:0] addr_q, addr_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   rec_len_q, rec_len_d;
  logic [DATA_W-1:0] dout_q, dout_d, sout_q, sout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic read_q, read_d, write_q, write_d, sv_q, sv_d, done_q, done_d, ovr_q, ovr_d;
  logic in_rec, in_play, do_stop, do_play, wr_last, rd_last, mem_full, play_end;

  assign in_rec   = (st_q == REC_WAIT) || (st_q == REC_WR);
  assign in_play  = (st_q == PLAY_WAIT) || (st_q == PLAY_RD);
  assign do_stop  = stop_req_i & (in_rec | in_play);
  // stop masks rec/play even in IDLE, where it is otherwise a no-op
  assign do_play  = ~stop_req_i & ~rec_req_i & play_req_i & ~in_rec;
  assign wr_last  = (st_q == REC_WR) && (cnt_q == CNT_W'(WR_CYCLES - 1));
  assign rd_last  = (st_q == PLAY_RD) && (cnt_q == CNT_W'(RD_CYCLES - 1));
  assign mem_full = wr_last && (addr_q == '1);
  assign play_end = rd_last && (({1'b0, rd_ptr_q} + (ADDR_W+1)'(1)) == rec_len_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q      <= IDLE;
      addr_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rec_len_q <= '0;
      dout_q    <= '0;
      sout_q    <= '0;
      cnt_q     <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      sv_q      <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      addr_q    <= addr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rec_len_q <= rec_len_d;
      dout_q    <= dout_d;
      sout_q    <= sout_d;
      cnt_q     <= cnt_d;
      read_q    <= read_d;
      write_q   <= write_d;
      sv_q      <= sv_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    st_d = st_q;
    if (stop_req_i) begin
      if (do_stop) st_d = IDLE;
    end else if (rec_req_i) begin
      st_d = REC_WAIT;
    end else if (do_play) begin
      st_d = (rec_len_q == '0) ? IDLE : PLAY_WAIT;
    end else begin
      case (st_q)
        REC_WAIT:  if (sample_tick_i) st_d = REC_WR;
        REC_WR:    if (wr_last) st_d = mem_full ? IDLE : REC_WAIT;
        PLAY_WAIT: if (sample_tick_i) st_d = PLAY_RD;
        PLAY_RD:   if (rd_last) st_d = play_end ? IDLE : PLAY_WAIT;
        default:   st_d = st_q;
      endcase
    end
  end

  always_comb begin
    addr_d    = addr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rec_len_d = rec_len_q;
    dout_d    = dout_q;
    sout_d    = sout_q;
    cnt_d     = cnt_q;
    read_d    = read_q;
    write_d   = write_q;
    sv_d      = 1'b0;
    done_d    = 1'b0;
    ovr_d     = ovr_q | (sample_tick_i & ((st_q == REC_WR) | (st_q == PLAY_RD)));
    if (stop_req_i) begin
      if (do_stop) begin
        read_d  = 1'b0;
        write_d = 1'b0;
        done_d  = 1'b1;
      end
    end else if (rec_req_i) begin
      wr_ptr_d  = '0;
      rec_len_d = '0;
      read_d    = 1'b0;
      write_d   = 1'b0;
      ovr_d     = 1'b0;
    end else if (do_play) begin
      ovr_d  = 1'b0;
      read_d = 1'b0;
      if (rec_len_q == '0) done_d = 1'b1;
      else rd_ptr_d = '0;
    end else begin
      case (st_q)
        REC_WAIT: if (sample_tick_i) begin
          dout_d  = sample_in_i;
          addr_d  = wr_ptr_q;
          write_d = 1'b1;
          cnt_d   = '0;
        end
        REC_WR: if (wr_last) begin
          write_d   = 1'b0;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          rec_len_d = rec_len_q + 1'b1;
          done_d    = mem_full;
        end else cnt_d = cnt_q + 1'b1;
        PLAY_WAIT: if (sample_tick_i) begin
          addr_d = rd_ptr_q;
          read_d = 1'b1;
          cnt_d  = '0;
        end
        PLAY_RD: if (rd_last) begin
          read_d   = 1'b0;
          sout_d   = data_in_i;
          sv_d     = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          done_d   = play_end;
        end else cnt_d = cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign data_out_o         = dout_q;
  assign addr_o             = addr_q;
  assign read_o             = read_q;
  assign write_o            = write_q;
  assign play_o             = in_play;
  assign record_o           = in_rec;
  assign sample_out_o       = sout_q;
  assign sample_out_valid_o = sv_q;
  assign rec_len_o          = rec_len_q;
  assign done_o             = done_q;
  assign overrun_o          = ovr_q;
endmodule

// File: tb/tb_audio_rec_ctrl.sv
// Bench for audio_rec_ctrl: a full-size and an 8-word instance run in lockstep,
// each compared every cycle against a mode / busy-countdown reference model.
module tb_audio_rec_ctrl;
  localparam int WRC = 2;
  localparam int RDC = 2;
  localparam int AWS = 3;

  logic gclk = 1'b0;
  logic rst, rec, play, stop, tick;
  logic [15:0] sin;
  always #5 gclk = ~gclk;

  logic [15:0] b_din, b_dout, b_sout, s_din, s_dout, s_sout;
  logic [17:0] b_addr;
  logic [2:0]  s_addr;
  logic [18:0] b_len;
  logic [3:0]  s_len;
  logic b_rd, b_wr, b_play, b_rec, b_sv, b_done, b_ovr;
  logic s_rd, s_wr, s_play, s_rec, s_sv, s_done, s_ovr;

  audio_rec_ctrl u_big (
    .clk_i(gclk), .reset_i(rst), .rec_req_i(rec), .play_req_i(play), .stop_req_i(stop),
    .sample_tick_i(tick), .sample_in_i(sin), .data_in_i(b_din), .data_out_o(b_dout),
    .addr_o(b_addr), .read_o(b_rd), .write_o(b_wr), .play_o(b_play), .record_o(b_rec),
    .sample_out_o(b_sout), .sample_out_valid_o(b_sv), .rec_len_o(b_len), .done_o(b_done),
    .overrun_o(b_ovr));

  audio_rec_ctrl #(.ADDR_W(AWS)) u_small (
    .clk_i(gclk), .reset_i(rst), .rec_req_i(rec), .play_req_i(play), .stop_req_i(stop),
    .sample_tick_i(tick), .sample_in_i(sin), .data_in_i(s_din), .data_out_o(s_dout),
    .addr_o(s_addr), .read_o(s_rd), .write_o(s_wr), .play_o(s_play), .record_o(s_rec),
    .sample_out_o(s_sout), .sample_out_valid_o(s_sv), .rec_len_o(s_len), .done_o(s_done),
    .overrun_o(s_ovr));

  // SRAM stand-ins: capture whatever the DUT writes, return it on reads
  logic [15:0] sram0 [4096];
  logic [15:0] sram1 [8];
  assign b_din = sram0[b_addr[11:0]];
  assign s_din = sram1[s_addr];
  always @(posedge gclk) begin
    if (b_wr) sram0[b_addr[11:0]] <= b_dout;
    if (s_wr) sram1[s_addr] <= s_dout;
  end

  // reference model: mode 0=idle 1=record 2=play, busy = cycles left in access
  int m_mode [2], m_busy [2], m_ptr [2], m_len [2];
  logic m_ovr [2], e_rd [2], e_wr [2], e_sv [2], e_done [2];
  logic [17:0] e_addr [2];
  logic [15:0] e_dout [2], e_sout [2];
  logic [15:0] m_data [2][4096];
  string nm [11] = '{"addr", "read", "write", "play", "record", "data_out",
                     "sample_out", "sample_out_valid", "rec_len", "done", "overrun"};

  int nvec = 0, nerr = 0;
  int sv_cnt, rd_cyc, swr_cyc, bwr_cyc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int full;
    full = (k == 0) ? (1 << 18) : (1 << AWS);
    e_done[k] = 1'b0;
    e_sv[k]   = 1'b0;
    if (rst) begin
      m_mode[k] = 0; m_busy[k] = 0; m_ptr[k] = 0; m_len[k] = 0; m_ovr[k] = 1'b0;
      e_rd[k] = 1'b0; e_wr[k] = 1'b0; e_addr[k] = '0; e_dout[k] = '0; e_sout[k] = '0;
    end else begin
      if (m_mode[k] != 0 && m_busy[k] > 0 && tick) m_ovr[k] = 1'b1;
      if (stop) begin
        if (m_mode[k] != 0) begin
          m_mode[k] = 0; m_busy[k] = 0; e_rd[k] = 1'b0; e_wr[k] = 1'b0; e_done[k] = 1'b1;
        end
      end else if (rec) begin
        m_mode[k] = 1; m_busy[k] = 0; m_ptr[k] = 0; m_len[k] = 0;
        e_rd[k] = 1'b0; e_wr[k] = 1'b0; m_ovr[k] = 1'b0;
      end else if (play && m_mode[k] != 1) begin
        m_ovr[k] = 1'b0; m_busy[k] = 0; e_rd[k] = 1'b0;
        if (m_len[k] == 0) begin m_mode[k] = 0; e_done[k] = 1'b1; end
        else begin m_mode[k] = 2; m_ptr[k] = 0; end
      end else if (m_busy[k] == 0) begin
        if (tick && m_mode[k] != 0) begin
          e_addr[k] = 18'(m_ptr[k]);
          if (m_mode[k] == 1) begin
            m_busy[k] = WRC; e_wr[k] = 1'b1; e_dout[k] = sin;
            m_data[k][m_ptr[k] % 4096] = sin;
          end else begin
            m_busy[k] = RDC; e_rd[k] = 1'b1;
          end
        end
      end else begin
        m_busy[k] = m_busy[k] - 1;
        if (m_busy[k] == 0) begin
          if (m_mode[k] == 1) begin
            e_wr[k] = 1'b0;
            m_len[k] = m_len[k] + 1;
            if (m_ptr[k] == full - 1) begin m_mode[k] = 0; e_done[k] = 1'b1; end
          end else begin
            e_rd[k] = 1'b0; e_sv[k] = 1'b1;
            e_sout[k] = m_data[k][m_ptr[k] % 4096];
            if (m_ptr[k] + 1 == m_len[k]) begin m_mode[k] = 0; e_done[k] = 1'b1; end
          end
          m_ptr[k] = m_ptr[k] + 1;
        end
      end
    end
  endtask

  task automatic compare(input int k);
    logic [31:0] act [11];
    logic [31:0] exp [11];
    string inst;
    inst = (k == 0) ? "big" : "small";
    if (k == 0)
      act = '{32'(b_addr), 32'(b_rd), 32'(b_wr), 32'(b_play), 32'(b_rec), 32'(b_dout),
              32'(b_sout), 32'(b_sv), 32'(b_len), 32'(b_done), 32'(b_ovr)};
    else
      act = '{32'(s_addr), 32'(s_rd), 32'(s_wr), 32'(s_play), 32'(s_rec), 32'(s_dout),
              32'(s_sout), 32'(s_sv), 32'(s_len), 32'(s_done), 32'(s_ovr)};
    exp = '{32'(e_addr[k]), 32'(e_rd[k]), 32'(e_wr[k]), 32'(m_mode[k] == 2),
            32'(m_mode[k] == 1), 32'(e_dout[k]), 32'(e_sout[k]), 32'(e_sv[k]),
            32'(m_len[k]), 32'(e_done[k]), 32'(m_ovr[k])};
    for (int i = 0; i < 11; i++) chk($sformatf("%s.%s", inst, nm[i]), act[i], exp[i]);
  endtask

  task automatic step(input logic r_rst, input logic r_rec, input logic r_play,
                      input logic r_stop, input logic r_tick, input logic [15:0] r_sin);
    rst = r_rst; rec = r_rec; play = r_play; stop = r_stop; tick = r_tick; sin = r_sin;
    @(posedge gclk);
    model_step(0);
    model_step(1);
    #1;
    compare(0);
    compare(1);
    if (b_sv) sv_cnt++;
    if (b_rd) rd_cyc++;
    if (b_wr) bwr_cyc++;
    if (s_wr) swr_cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic tk(input logic [15:0] v);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, v);
    idle(3);
  endtask

  initial begin
    logic [15:0] smp [4];
    smp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    sv_cnt = 0; rd_cyc = 0; swr_cyc = 0; bwr_cyc = 0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("rst.rec_len", 32'(b_len), 32'd0);

    // record four samples, then stop
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    idle(2);
    for (int i = 0; i < 4; i++) tk(smp[i]);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("rec4.done", 32'(b_done), 32'd1);
    idle(2);
    chk("rec4.rec_len", 32'(b_len), 32'd4);

    // play them back; ends by itself after the fourth read
    sv_cnt = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    idle(1);
    for (int i = 0; i < 4; i++) tk(16'(i));
    chk("play4.sv_cnt", 32'(sv_cnt), 32'd4);
    chk("play4.last", 32'(b_sout), 32'h4444);
    chk("play4.play", 32'(b_play), 32'd0);

    // play with nothing recorded
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    rd_cyc = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("empty.done", 32'(b_done), 32'd1);
    tk(16'h5a5a);
    chk("empty.reads", 32'(rd_cyc), 32'd0);

    // ten ticks: the 8-word instance fills at 8 and stops
    swr_cyc = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    idle(1);
    for (int i = 0; i < 10; i++) tk(16'($urandom));
    chk("full.small_len", 32'(s_len), 32'd8);
    chk("full.small_wr_cyc", 32'(swr_cyc), 32'd16);
    chk("full.big_len", 32'(b_len), 32'd10);

    // back-to-back ticks: second one lands mid-write
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(1);
    bwr_cyc = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hbeef);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hdead);
    idle(3);
    chk("ovr.set", 32'(b_ovr), 32'd1);
    chk("ovr.one_write", 32'(bwr_cyc), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("ovr.clr", 32'(b_ovr), 32'd0);

    // request priority
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("prio.no_done", 32'(b_done), 32'd0);
    chk("prio.idle", 32'(b_rec), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("prio.record", 32'(b_rec), 32'd1);
    chk("prio.play", 32'(b_play), 32'd0);

    // random traffic
    repeat (4000) begin
      step($urandom_range(0, 1499) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 79) == 0, $urandom_range(0, 119) == 0,
           $urandom_range(0, 4) == 0, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/audio_rec_ctrl.md
Name: audio_rec_ctrl

Overview:
- Record/playback sequencer that sits directly upstream of the SRAM interface block and drives its addr, read, write, play and record inputs.
- On each codec sample tick it either writes the incoming ADC sample to the next SRAM word (record) or reads the next stored word and presents it to the DAC path (play).
- It tracks the recorded length, stops playback at the end of the recording, and stops recording when memory is full.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 16, sample width.
- WR_CYCLES, 2, clk cycles `write` is held per access (≥1).
- RD_CYCLES, 2, clk cycles `read` is held per access (≥1). Data is sampled on the last cycle.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rec_req  in  1  one-cycle pulse: start recording from address 0.
- play_req  in  1  one-cycle pulse: start playback from address 0.
- stop_req  in  1  one-cycle pulse: abort the current mode.
- sample_tick  in  1  one-cycle pulse per audio sample period.
- sample_in  in  DATA_W  ADC sample, valid on sample_tick.
- data_in  in  DATA_W  word returned from the SRAM interface data bus.
- data_out  out  DATA_W  word to drive onto the SRAM interface data bus while record=1.
- addr  out  ADDR_W  SRAM word address.
- read  out  1  read strobe to the SRAM interface.
- write  out  1  write strobe to the SRAM interface.
- play  out  1  high while in a PLAY_* state.
- record  out  1  high while in a REC_* state.
- sample_out  out  DATA_W  last word played back.
- sample_out_valid  out  1  one-cycle pulse when sample_out updates.
- rec_len  out  ADDR_W+1  number of words in the current recording.
- done  out  1  one-cycle pulse when play or record ends for any reason.
- overrun  out  1  sticky: a sample_tick arrived while an access was in progress.

Behaviour:
- Reset values: state=IDLE; addr=0, read=0, write=0, play=0, record=0, data_out=0, sample_out=0, sample_out_valid=0, rec_len=0, done=0, overrun=0. Internal pointers wr_ptr=rd_ptr=0, access counter=0.
- Invariant: read and write are never high in the same cycle. Both are registered outputs.
- States: IDLE, REC_WAIT, REC_WR, PLAY_WAIT, PLAY_RD.
- Request priority when several are high in one cycle: stop_req > rec_req > play_req. All three are evaluated in every state.
- rec_req from any state:
  - clears wr_ptr and rec_len;
  - goes to REC_WAIT next cycle;
  - aborts any access in progress (read/write drop next cycle).
- play_req outside REC_*:
  - if rec_len==0: stay in IDLE and pulse done the next cycle; no read is issued;
  - otherwise clear rd_ptr and go to PLAY_WAIT.
- play_req while in REC_* is ignored.
- stop_req in REC_* or PLAY_*:
  - go to IDLE next cycle and pulse done;
  - an in-progress write is dropped without counting, so rec_len keeps only completed writes.
- stop_req in IDLE: no effect, no done pulse.
- REC_WAIT:
  - on sample_tick: latch sample_in into data_out; set addr=wr_ptr; assert write; go to REC_WR.
- REC_WR:
  - hold write for exactly WR_CYCLES cycles;
  - on the cycle write deasserts: wr_ptr+=1 and rec_len+=1;
  - if the completed write was at address 2^ADDR_W−1 (memory full): go to IDLE and pulse done, with rec_len=2^ADDR_W. Otherwise return to REC_WAIT.
  - The address is never wrapped.
- PLAY_WAIT:
  - on sample_tick: set addr=rd_ptr; assert read; go to PLAY_RD.
- PLAY_RD:
  - hold read for RD_CYCLES cycles;
  - on the last of those cycles, register data_in into sample_out; pulse sample_out_valid on the following cycle, with read deasserted;
  - rd_ptr+=1;
  - if rd_ptr+1 == rec_len: go to IDLE and pulse done; otherwise return to PLAY_WAIT.
- sample_tick in REC_WR or PLAY_RD: ignored for data purposes and sets overrun. overrun is cleared only by reset or rec_req/play_req.
- sample_tick in IDLE: ignored and does not set overrun.
- play and record are decoded from the registered state; record=1 exactly in REC_WAIT and REC_WR.
- addr holds its last value in the WAIT states and in IDLE.
- Reset asserted mid-access: all outputs return to their reset values on the next edge, and rec_len is lost.

Test Plan:
- Reset, then rec_req, then 4 ticks with sample_in = 0x1111, 0x2222, 0x3333, 0x4444, then stop_req → writes at addr 0..3, each write high exactly 2 cycles, data_out matches each sample, rec_len=4, one done pulse.
- play_req after that recording, then 4 ticks with data_in model returning mem[addr] → reads at addr 0..3, sample_out_valid pulses 4 times with 0x1111..0x4444, auto-return to IDLE with done after the 4th read, play=0.
- After reset, play_req → no read ever asserted, done pulses once, state stays IDLE.
- ADDR_W=3 build, rec_req, 10 ticks → 8 writes (addr 0..7), rec_len=8, done after the 8th write, ticks 9–10 cause no write.
- rec_req, tick, then a second tick 1 cycle later (during REC_WR) → only one write occurs and overrun=1; a subsequent rec_req clears overrun.
- rec_req, play_req and stop_req in the same cycle while IDLE → no state change and no done; then rec_req+play_req together → REC_WAIT, record=1, play=0.
